// File: rtl/seq_muldiv.sv
// seq_muldiv: radix-2 multi-cycle multiply (shift-add) / divide (restoring) with start/done handshake.
// Optional signed mode: define SEQ_MULDIV_SIGNED_EN to add the i_sgn port (two's-complement operands).
module seq_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_op,
`ifdef SEQ_MULDIV_SIGNED_EN
  input  logic             i_sgn,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result_lo,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_dbz
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          OP_DIV   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic                 r_busy;
  logic                 r_done;
  logic                 r_op;
  logic                 r_neg_a;
  logic                 r_neg_b;
  logic                 r_dbz_pend;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_mpnd;
  logic [WIDTH-1:0]     r_mplr;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH:0]       r_rem;
  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH-1:0]     r_dvsr;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_hi;
  logic                 r_dbz;

  logic                 w_accept;
  logic                 w_sgn;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_mul_acc_nx;
  logic [WIDTH:0]       w_rem_sh;
  logic                 w_rem_ge;
  logic [WIDTH:0]       w_rem_nx;
  logic [WIDTH-1:0]     w_quo_nx;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [WIDTH-1:0]     w_a_orig;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? ({2*WIDTH{1'b0}} - v) : v;
  endfunction

`ifdef SEQ_MULDIV_SIGNED_EN
  assign w_sgn = i_sgn;
`else
  assign w_sgn = 1'b0;
`endif

  // Operands iterate as magnitudes; signs are remembered for the final fix-up.
  assign w_neg_a  = w_sgn & i_a[WIDTH-1];
  assign w_neg_b  = w_sgn & i_b[WIDTH-1];
  assign w_a_mag  = cond_neg_w(w_neg_a, i_a);
  assign w_b_mag  = cond_neg_w(w_neg_b, i_b);
  assign w_accept = i_start & ~r_busy;

  assign w_mul_acc_nx = r_acc + (r_mplr[0] ? r_mpnd : {2*WIDTH{1'b0}});

  // Remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
  assign w_rem_sh = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_rem_ge = (w_rem_sh >= {1'b0, r_dvsr});
  assign w_rem_nx = w_rem_ge ? (w_rem_sh - {1'b0, r_dvsr}) : w_rem_sh;
  assign w_quo_nx = {r_dvd[WIDTH-2:0], w_rem_ge};

  assign w_prod_fix = cond_neg_2w(r_neg_a ^ r_neg_b, w_mul_acc_nx);
  assign w_quo_fix  = cond_neg_w(r_neg_a ^ r_neg_b, w_quo_nx);
  assign w_rem_fix  = cond_neg_w(r_neg_a, w_rem_nx[WIDTH-1:0]);
  assign w_a_orig   = cond_neg_w(r_neg_a, r_dvd);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nx = S_RUN;
        else          w_state_nx = S_IDLE;
      end
      S_RUN: begin
        if (r_dbz_pend || (r_cnt == CNT_ONE)) w_state_nx = S_DONE;
        else                                  w_state_nx = S_RUN;
      end
      S_DONE: begin
        if (w_accept) w_state_nx = S_RUN;
        else          w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx == S_RUN);
      r_done  <= (w_state_nx == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_cnt      <= {CW{1'b0}};
      r_mpnd     <= {2*WIDTH{1'b0}};
      r_mplr     <= {WIDTH{1'b0}};
      r_acc      <= {2*WIDTH{1'b0}};
      r_rem      <= {(WIDTH+1){1'b0}};
      r_dvd      <= {WIDTH{1'b0}};
      r_dvsr     <= {WIDTH{1'b0}};
      r_lo       <= {WIDTH{1'b0}};
      r_hi       <= {WIDTH{1'b0}};
      r_dbz      <= 1'b0;
    end else if (w_accept) begin
      r_op       <= i_op;
      r_neg_a    <= w_neg_a;
      r_neg_b    <= w_neg_b;
      r_dbz_pend <= (i_op == OP_DIV) && (i_b == {WIDTH{1'b0}});
      r_cnt      <= CNT_INIT;
      r_mpnd     <= {{WIDTH{1'b0}}, w_a_mag};
      r_mplr     <= w_b_mag;
      r_acc      <= {2*WIDTH{1'b0}};
      r_rem      <= {(WIDTH+1){1'b0}};
      r_dvd      <= w_a_mag;
      r_dvsr     <= w_b_mag;
      r_dbz      <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (r_dbz_pend) begin
        // Divide-by-zero skips iteration; the dividend is still intact in r_dvd.
        r_lo  <= {WIDTH{1'b1}};
        r_hi  <= w_a_orig;
        r_dbz <= 1'b1;
      end else begin
        r_cnt  <= r_cnt - CNT_ONE;
        r_mpnd <= r_mpnd << 1;
        r_mplr <= r_mplr >> 1;
        r_acc  <= w_mul_acc_nx;
        r_rem  <= w_rem_nx;
        r_dvd  <= w_quo_nx;
        if (r_cnt == CNT_ONE) begin
          if (r_op == OP_DIV) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end else begin
            r_lo <= w_prod_fix[WIDTH-1:0];
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          end
        end
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_result_lo = r_lo;
  assign o_result_hi = r_hi;
  assign o_dbz       = r_dbz;

endmodule

// File: tb/tb_seq_muldiv.sv
// Self-checking bench for seq_muldiv: directed cases plus random ops against an arithmetic model.
module tb_seq_muldiv;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic         i_op;
  logic         i_sgn;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_result_lo;
  logic [W-1:0] o_result_hi;
  logic         o_dbz;

  int n_checks = 0;
  int n_errors = 0;

  seq_muldiv #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_op        (i_op),
`ifdef SEQ_MULDIV_SIGNED_EN
    .i_sgn       (i_sgn),
`endif
    .i_a         (i_a),
    .i_b         (i_b),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_result_lo (o_result_lo),
    .o_result_hi (o_result_hi),
    .o_dbz       (o_dbz)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as the specification defines them.
  task automatic model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dbz,
                       output int lat);
    longint xa, xb, r;
    xa = sgn ? longint'($signed(a)) : longint'(a);
    xb = sgn ? longint'($signed(b)) : longint'(b);
    dbz = 1'b0;
    lat = W;
    if (!op) begin
      r  = xa * xb;
      lo = r[W-1:0];
      hi = r[2*W-1:W];
    end else if (b == '0) begin
      lo  = {W{1'b1}};
      hi  = a;
      dbz = 1'b1;
      lat = 1;
    end else begin
      r  = xa / xb;
      lo = r[W-1:0];
      r  = xa % xb;
      hi = r[W-1:0];
    end
  endtask

  // Issue one op (start held during the current cycle), track latency/busy, check results.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input int inj);
    logic [W-1:0] e_lo, e_hi;
    logic         e_dbz;
    int           lat, n;
    logic         seen, busy_ok;
    model(op, a, b, sgn, e_lo, e_hi, e_dbz, lat);
    i_start = 1'b1; i_op = op; i_a = a; i_b = b; i_sgn = sgn;
    @(posedge clk); #1;
    i_start = 1'b0; i_op = 1'($urandom); i_a = W'($urandom); i_b = W'($urandom);
    check_eq("busy_after_accept", 64'(o_busy), 64'd1);
    check_eq("dbz_cleared", 64'(o_dbz), 64'd0);
    n = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n < 3 * W) begin
      if (n + 1 == inj) begin
        i_start = 1'b1; i_op = 1'b1; i_b = '0;
      end
      @(posedge clk); #1;
      n++;
      i_start = 1'b0;
      if (o_done) seen = 1'b1;
      else if (!o_busy) busy_ok = 1'b0;
    end
    check_eq("latency", 64'(n), 64'(lat));
    check_eq("busy_while_run", 64'(busy_ok), 64'd1);
    check_eq("busy_at_done", 64'(o_busy), 64'd0);
    check_eq("result_lo", 64'(o_result_lo), 64'(e_lo));
    check_eq("result_hi", 64'(o_result_hi), 64'(e_hi));
    check_eq("dbz", 64'(o_dbz), 64'(e_dbz));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic op, sg;
    logic [W-1:0] a, b;
    logic seen_done;
    rst = 1'b1; i_start = 1'b0; i_op = 1'b0; i_sgn = 1'b0; i_a = '0; i_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(o_busy), 64'd0);
    check_eq("rst_done", 64'(o_done), 64'd0);
    check_eq("rst_lo", 64'(o_result_lo), 64'd0);
    check_eq("rst_hi", 64'(o_result_hi), 64'd0);
    check_eq("rst_dbz", 64'(o_dbz), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 16'd300, 16'd200, 1'b0, 0);
    check_eq("mul_300x200_lo", 64'(o_result_lo), 64'h0000_EA60);
    @(posedge clk); #1;
    check_eq("done_one_cycle", 64'(o_done), 64'd0);
    check_eq("result_held", 64'(o_result_lo), 64'h0000_EA60);

    run_op(1'b1, 16'd25, 16'd7, 1'b0, 0);
    run_op(1'b1, 16'd75, 16'd11, 1'b0, 0);   // issued in the DONE cycle
    run_op(1'b1, 16'd1234, 16'd0, 1'b0, 0);
    @(posedge clk); #1;
    check_eq("dbz_held", 64'(o_dbz), 64'd1);
    run_op(1'b1, 16'd35, 16'd5, 1'b0, 0);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 0);
    check_eq("mul_max_hi", 64'(o_result_hi), 64'h0000_FFFE);

    // Start pulsed during RUN must be ignored.
    run_op(1'b0, 16'd300, 16'd200, 1'b0, 3);
    check_eq("ignored_start_lo", 64'(o_result_lo), 64'h0000_EA60);
    @(posedge clk); #1;
    check_eq("no_extra_accept", 64'(o_busy), 64'd0);

    // Reset mid-operation aborts without a done pulse.
    i_start = 1'b1; i_op = 1'b0; i_a = 16'd7; i_b = 16'd9;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_busy", 64'(o_busy), 64'd0);
    check_eq("abort_done", 64'(o_done), 64'd0);
    check_eq("abort_lo", 64'(o_result_lo), 64'd0);
    check_eq("abort_hi", 64'(o_result_hi), 64'd0);
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_done || o_busy) seen_done = 1'b1;
    end
    check_eq("abort_no_done", 64'(seen_done), 64'd0);
    run_op(1'b0, 16'd3, 16'd4, 1'b0, 0);
    check_eq("mul_3x4_after_rst", 64'(o_result_lo), 64'd12);

`ifdef SEQ_MULDIV_SIGNED_EN
    run_op(1'b1, 16'hFFF9, 16'd2, 1'b1, 0);
    check_eq("sdiv_m7_2_lo", 64'(o_result_lo), 64'h0000_FFFD);
    run_op(1'b0, 16'hFFFD, 16'd5, 1'b1, 0);
    check_eq("smul_m3_5_lo", 64'(o_result_lo), 64'h0000_FFF1);
    run_op(1'b1, 16'h8000, 16'hFFFF, 1'b1, 0);
    check_eq("sdiv_min_m1_lo", 64'(o_result_lo), 64'h0000_8000);
    run_op(1'b1, 16'hFF00, 16'd0, 1'b1, 0);
`endif

    for (int i = 0; i < 400; i++) begin
      op = 1'($urandom);
      a  = W'($urandom);
      b  = W'($urandom);
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = W'($urandom_range(1, 3));
        2: a = {W{1'b1}};
        default: ;
      endcase
`ifdef SEQ_MULDIV_SIGNED_EN
      sg = 1'($urandom);
`else
      sg = 1'b0;
`endif
      run_op(op, a, b, sg, 0);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
